q_action_select: RTL and testbench

Policy/read side of the maze Q-learning datapath. On request it reads the four action values of one maze state from the 36×4 Q-table RAM and returns the greedy max (max_Q, used by the Q-update stage). It also returns the action to take, chosen epsilon-greedy with an internal LFSR. Walls are excluded via a per-state valid-action mask. Sits between the maze/agent controller and the Q-table memory.

---
 rtl/q_action_select.sv | 145 ++++++++++++++
 tb/tb_q_action_select.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/q_action_select.sv
// Policy/read side of the maze Q-learning datapath: reads one state's four Q-values,
// returns the signed greedy max and an epsilon-greedy action chosen via an internal LFSR.
`timescale 1ns/1ps
module q_action_select #(
  parameter int          N_STATES  = 36,
  parameter logic [7:0]  EPSILON   = 8'd26,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  state,
  input  logic [3:0]  valid_mask,
  output logic        q_rd_en,
  output logic [5:0]  q_rd_state,
  output logic [1:0]  q_rd_action,
  input  logic [31:0] q_rd_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] max_Q,
  output logic [2:0]  action,
  output logic [1:0]  greedy_action,
  output logic        explored,
  output logic        no_legal
);

  localparam logic [5:0] LAST_STATE = 6'(N_STATES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fsm_t;

  fsm_t        cur_st, nxt_st;
  logic [5:0]  cap_state;
  logic [3:0]  cap_mask;
  logic [7:0]  rnd_p;
  logic [1:0]  rnd_a;
  logic [1:0]  fetch_idx;
  logic        rd_pend;
  logic [1:0]  rd_idx;
  logic [31:0] best_q;
  logic [1:0]  best_idx;
  logic        best_vld;
  logic [15:0] lfsr;
  logic        accept;
  logic        explore;

  // The done-pulse cycle is already IDLE but must still refuse a new request.
  assign accept     = start && (cur_st == IDLE) && !done;
  assign explore    = (rnd_p < EPSILON) && cap_mask[rnd_a];
  assign q_rd_state = cap_state;

  always_ff @(posedge clk) begin
    if (reset) cur_st <= IDLE;
    else       cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st      = cur_st;
    q_rd_en     = 1'b0;
    q_rd_action = 2'd0;
    busy        = 1'b1;
    case (cur_st)
      IDLE: begin
        busy = 1'b0;
        if (accept) nxt_st = FETCH;
      end
      FETCH: begin
        q_rd_en     = 1'b1;
        q_rd_action = fetch_idx;
        if (fetch_idx == 2'd3) nxt_st = DRAIN;
      end
      DRAIN:   nxt_st = DONE;
      DONE:    nxt_st = IDLE;
      default: nxt_st = IDLE;
    endcase
  end

  // Read data lags the strobe by one cycle, so the column travels alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_state <= 6'd0;
      cap_mask  <= 4'd0;
      rnd_p     <= 8'd0;
      rnd_a     <= 2'd0;
      fetch_idx <= 2'd0;
      rd_pend   <= 1'b0;
      rd_idx    <= 2'd0;
      best_q    <= 32'd0;
      best_idx  <= 2'd0;
      best_vld  <= 1'b0;
    end else begin
      rd_pend <= q_rd_en;
      rd_idx  <= q_rd_action;
      if (accept) begin
        cap_state <= (state > LAST_STATE) ? LAST_STATE : state;
        cap_mask  <= valid_mask;
        rnd_p     <= lfsr[7:0];
        rnd_a     <= lfsr[9:8];
        fetch_idx <= 2'd0;
        best_vld  <= 1'b0;
      end
      if (cur_st == FETCH) fetch_idx <= fetch_idx + 2'd1;
      if (rd_pend && cap_mask[rd_idx] &&
          (!best_vld || ($signed(q_rd_data) > $signed(best_q)))) begin
        best_q   <= q_rd_data;
        best_idx <= rd_idx;
        best_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done          <= 1'b0;
      max_Q         <= 32'd0;
      action        <= 3'd0;
      greedy_action <= 2'd0;
      explored      <= 1'b0;
      no_legal      <= 1'b0;
    end else begin
      done <= (cur_st == DONE);
      if (cur_st == DONE) begin
        if (cap_mask == 4'd0) begin
          max_Q         <= 32'd0;
          greedy_action <= 2'd0;
          action        <= 3'd0;
          explored      <= 1'b0;
          no_legal      <= 1'b1;
        end else begin
          max_Q         <= best_q;
          greedy_action <= best_idx;
          action        <= explore ? {1'b0, rnd_a} : {1'b0, best_idx};
          explored      <= explore;
          no_legal      <= 1'b0;
        end
      end
    end
  end

  // Right-shifting Fibonacci form of the x^16+x^14+x^13+x^11+1 polynomial.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

endmodule

// File: tb/tb_q_action_select.sv
// Directed bench for q_action_select: a greedy instance and an always-explore instance
// share stimulus, each backed by its own one-cycle-latency Q-table model.
`timescale 1ns/1ps
module tb_q_action_select;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  req_state;
  logic [3:0]  req_mask;

  logic        q_rd_en_g, q_rd_en_e;
  logic [5:0]  q_rd_state_g, q_rd_state_e;
  logic [1:0]  q_rd_action_g, q_rd_action_e;
  logic [31:0] q_rd_data_g, q_rd_data_e;
  logic        busy_g, busy_e, done_g, done_e;
  logic [31:0] max_q_g, max_q_e;
  logic [2:0]  action_g, action_e;
  logic [1:0]  greedy_g, greedy_e;
  logic        explored_g, explored_e, no_legal_g, no_legal_e;

  logic [31:0] qmem [0:63][0:3];
  logic [15:0] ref_lfsr;
  int          checks;
  int          fails;

  q_action_select #(.N_STATES(36), .EPSILON(8'd0), .LFSR_SEED(16'hACE1)) u_greedy (
    .clk(clk), .reset(reset), .start(start), .state(req_state), .valid_mask(req_mask),
    .q_rd_en(q_rd_en_g), .q_rd_state(q_rd_state_g), .q_rd_action(q_rd_action_g),
    .q_rd_data(q_rd_data_g), .busy(busy_g), .done(done_g), .max_Q(max_q_g),
    .action(action_g), .greedy_action(greedy_g), .explored(explored_g), .no_legal(no_legal_g)
  );

  q_action_select #(.N_STATES(36), .EPSILON(8'd255), .LFSR_SEED(16'hACE1)) u_explore (
    .clk(clk), .reset(reset), .start(start), .state(req_state), .valid_mask(req_mask),
    .q_rd_en(q_rd_en_e), .q_rd_state(q_rd_state_e), .q_rd_action(q_rd_action_e),
    .q_rd_data(q_rd_data_e), .busy(busy_e), .done(done_e), .max_Q(max_q_e),
    .action(action_e), .greedy_action(greedy_e), .explored(explored_e), .no_legal(no_legal_e)
  );

  always #5 clk = ~clk;

  // Garbage outside a read return exposes any mis-timed sampling.
  always @(posedge clk) begin
    q_rd_data_g <= q_rd_en_g ? qmem[q_rd_state_g][q_rd_action_g] : 32'hDEADBEEF;
    q_rd_data_e <= q_rd_en_e ? qmem[q_rd_state_e][q_rd_action_e] : 32'hDEADBEEF;
  end

  always @(posedge clk) begin
    if (reset) ref_lfsr <= 16'hACE1;
    else       ref_lfsr <= {ref_lfsr[0] ^ ref_lfsr[2] ^ ref_lfsr[3] ^ ref_lfsr[5], ref_lfsr[15:1]};
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic refGreedy(input logic [5:0] st, input logic [3:0] msk,
                           output logic [31:0] mx, output logic [1:0] idx);
    logic [5:0] row;
    logic       vld;
    row = (st > 6'd35) ? 6'd35 : st;
    mx  = 32'd0;
    idx = 2'd0;
    vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (msk[k] && (!vld || ($signed(qmem[row][k]) > $signed(mx)))) begin
        mx  = qmem[row][k];
        idx = 2'(k);
        vld = 1'b1;
      end
    end
  endtask

  task automatic applyReset(input bit check_vals);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    if (check_vals) begin
      checkOutput("rst_busy",     32'(busy_g),        32'd0);
      checkOutput("rst_done",     32'(done_g),        32'd0);
      checkOutput("rst_rd_en",    32'(q_rd_en_g),     32'd0);
      checkOutput("rst_rd_state", 32'(q_rd_state_g),  32'd0);
      checkOutput("rst_rd_act",   32'(q_rd_action_g), 32'd0);
      checkOutput("rst_max_q",    max_q_g,            32'd0);
      checkOutput("rst_action",   32'(action_g),      32'd0);
      checkOutput("rst_greedy",   32'(greedy_g),      32'd0);
      checkOutput("rst_explored", 32'(explored_e),    32'd0);
      checkOutput("rst_no_legal", 32'(no_legal_g),    32'd0);
    end
    reset = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge of cycle T+8.
  task automatic applyStimulus(input logic [5:0] st, input logic [3:0] msk,
                               input logic [31:0] exp_max, input logic [1:0] exp_greedy,
                               input bit exp_nolegal, input bit timing, input bit extra_starts);
    logic [5:0] row;
    logic [7:0] rp;
    logic [1:0] ra;
    bit         exp_explore;
    logic [2:0] exp_act_e;
    row         = (st > 6'd35) ? 6'd35 : st;
    start       = 1'b1;
    req_state   = st;
    req_mask    = msk;
    rp          = ref_lfsr[7:0];
    ra          = ref_lfsr[9:8];
    exp_explore = (rp < 8'd255) && msk[ra];
    exp_act_e   = exp_explore ? {1'b0, ra} : {1'b0, exp_greedy};
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1 || k == 4 || k == 8) start = 1'b0;
      if (extra_starts && (k == 3 || k == 7)) begin
        start     = 1'b1;
        req_state = 6'd9;
        req_mask  = 4'b1111;
      end
      checkOutput("done_g", 32'(done_g), 32'(k == 7));
      checkOutput("done_e", 32'(done_e), 32'(k == 7));
      if (timing) begin
        checkOutput("busy_g", 32'(busy_g),    32'(k <= 6));
        checkOutput("busy_e", 32'(busy_e),    32'(k <= 6));
        checkOutput("rd_en",  32'(q_rd_en_g), 32'(k <= 4));
        if (k <= 4) begin
          checkOutput("rd_state",  32'(q_rd_state_g),  32'(row));
          checkOutput("rd_action", 32'(q_rd_action_g), 32'(k - 1));
        end
      end
      if (k == 7) begin
        checkOutput("max_q_g",    max_q_g,             exp_max);
        checkOutput("greedy_g",   32'(greedy_g),       32'(exp_greedy));
        checkOutput("action_g",   32'(action_g),       32'({1'b0, exp_greedy}));
        checkOutput("explored_g", 32'(explored_g),     32'd0);
        checkOutput("no_legal_g", 32'(no_legal_g),     32'(exp_nolegal));
        checkOutput("max_q_e",    max_q_e,             exp_max);
        checkOutput("greedy_e",   32'(greedy_e),       32'(exp_greedy));
        checkOutput("action_e",   32'(action_e),       32'(exp_act_e));
        checkOutput("explored_e", 32'(explored_e),     32'(exp_explore));
        checkOutput("no_legal_e", 32'(no_legal_e),     32'(exp_nolegal));
        if (msk != 4'd0) checkOutput("act_in_mask", 32'(msk[action_e[1:0]]), 32'd1);
      end
      if (k == 8) begin
        checkOutput("hold_max_q", max_q_g,     exp_max);
        checkOutput("busy_t8",    32'(busy_g), 32'd0);
      end
    end
  endtask

  task automatic resetMidRequest();
    start     = 1'b1;
    req_state = 6'd5;
    req_mask  = 4'b1111;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 4) reset = 1'b1;
      if (k == 5) begin
        reset = 1'b0;
        checkOutput("abort_max_q", max_q_g, 32'd0);
      end
      if (k >= 5) begin
        checkOutput("abort_busy",   32'(busy_g),    32'd0);
        checkOutput("abort_rd_en",  32'(q_rd_en_g), 32'd0);
        checkOutput("abort_done_g", 32'(done_g),    32'd0);
        checkOutput("abort_done_e", 32'(done_e),    32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] mx;
    logic [1:0]  ix;
    logic [5:0]  st;
    clk       = 1'b0;
    reset     = 1'b1;
    start     = 1'b0;
    req_state = 6'd0;
    req_mask  = 4'd0;
    checks    = 0;
    fails     = 0;
    for (int r = 0; r < 64; r++)
      for (int a = 0; a < 4; a++) qmem[r][a] = $urandom;
    qmem[5][0]  = 32'h00010000; qmem[5][1]  = 32'h00050000;
    qmem[5][2]  = 32'h0006E600; qmem[5][3]  = 32'h00020000;
    qmem[6][0]  = 32'hFFFF0000; qmem[6][1]  = 32'hFFFE0000;
    qmem[6][2]  = 32'hFFFF0000; qmem[6][3]  = 32'h80000000;
    qmem[7][0]  = 32'h00090000; qmem[7][1]  = 32'h00010000;
    qmem[7][2]  = 32'h00020000; qmem[7][3]  = 32'h00030000;
    qmem[35][0] = 32'h00000100; qmem[35][1] = 32'h00000200;
    qmem[35][2] = 32'h00000050; qmem[35][3] = 32'h00000200;

    applyReset(1'b1);
    applyStimulus(6'd5,  4'b1111, 32'h0006E600, 2'd2, 1'b0, 1'b1, 1'b0);
    applyStimulus(6'd6,  4'b1111, 32'hFFFF0000, 2'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(6'd7,  4'b1110, 32'h00030000, 2'd3, 1'b0, 1'b1, 1'b0);
    applyStimulus(6'd7,  4'b0000, 32'h00000000, 2'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(6'd40, 4'b1111, 32'h00000200, 2'd1, 1'b0, 1'b1, 1'b0);
    applyStimulus(6'd5,  4'b1111, 32'h0006E600, 2'd2, 1'b0, 1'b1, 1'b1);
    resetMidRequest();
    applyStimulus(6'd6,  4'b1111, 32'hFFFF0000, 2'd0, 1'b0, 1'b1, 1'b0);

    applyReset(1'b0);
    for (int i = 0; i < 64; i++) begin
      st = 6'(i % 36);
      refGreedy(st, 4'b0101, mx, ix);
      applyStimulus(st, 4'b0101, mx, ix, 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
